reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
// Parametrised power-on/brown-out reset supervisor. It follows the single-output power-on
// reset model and replaces its fixed delay with clocked sequencing.
// - Synchronises an asynchronous power-good input and debounces it.
// - Releases NUM_CH active-low reset domains one after another, STAGE_DELAY cycles apart.
// - Re-asserts all domains on brown-out or software request.
// - Sits between the board POR/supply monitor and the per-domain reset nets of the design.
// PARAMETERS
// NUM_CH       4   number of sequenced reset outputs (>=1); channel 0 is released first
// DEBOUNCE     16  consecutive synced-good cycles required before the first release (>=1)
// STAGE_DELAY  8   cycles between successive channel releases (>=1)
// SYNC_STAGES  2   flip-flop stages synchronising PWR_GOOD (>=2)
// PORTS
// CLK        in   1                   system clock, all logic on rising edge
// RESET_N    in   1                   synchronous, active-low reset
// PWR_GOOD   in   1                   asynchronous supply-good indication, high = good
// SW_RST     in   1                   synchronous level request to hold or re-enter reset
// RST_N_OUT  out  NUM_CH              active-low per-domain resets, registered
// READY      out  1                   high once all channels are released
// STAGE      out  $clog2(NUM_CH+1)    number of channels currently released
// EVT_CNT    out  8                   brown-out event counter, saturates at 255
// BEHAVIOUR
// - Reset (RESET_N=0 at a CLK edge):
//   RST_N_OUT=0, READY=0, STAGE=0, EVT_CNT=0, sync flops=0, counter=0, state=HOLD.
// - pg_s is PWR_GOOD after SYNC_STAGES flops. The FSM uses only pg_s, never raw PWR_GOOD.
// - States are HOLD, DEBOUNCE, RELEASE, RUN. Every output is a flop; outputs never glitch.
// - HOLD: all outputs 0. If pg_s=1 and SW_RST=0, go to DEBOUNCE with cnt=0; otherwise stay.
// - DEBOUNCE: on each edge with pg_s=1 and SW_RST=0:
//   - if cnt==DEBOUNCE-1, go to RELEASE, set RST_N_OUT[0]=1, STAGE=1, cnt=0;
//   - else cnt++.
//   - pg_s=0 or SW_RST=1: return to HOLD, cnt=0, EVT_CNT unchanged.
// - RELEASE: cnt counts 0..STAGE_DELAY-1. At wrap, release channel STAGE
//   (RST_N_OUT[STAGE]=1) and increment STAGE.
//   - Released channels stay 1; bits are released strictly in index order.
//   - On the edge that releases channel NUM_CH-1, go to RUN and set READY=1 on that same edge.
//   - NUM_CH=1: READY rises together with channel 0 on DEBOUNCE exit.
// - RUN: outputs hold: all 1, READY=1, STAGE=NUM_CH.
// - Brown-out (pg_s=0 in RELEASE or RUN):
//   - on the next edge, all RST_N_OUT=0, READY=0, STAGE=0, cnt=0, state=HOLD;
//   - EVT_CNT += 1, saturating at 255.
//   - Latency from PWR_GOOD falling to reset asserted: SYNC_STAGES+1 edges.
// - SW_RST=1 in RELEASE or RUN: same as brown-out, but EVT_CNT is unchanged.
//   - SW_RST held keeps the block in HOLD.
//   - After SW_RST falls, the full debounce and sequence repeats.
// - pg_s=0 and SW_RST=1 on the same edge: treat as brown-out, so EVT_CNT increments.
// - PWR_GOOD glitch shorter than DEBOUNCE synced cycles in DEBOUNCE:
//   no channel is released and the counter restarts from 0.
// - RESET_N=0 mid-sequence: all state and EVT_CNT are cleared on that edge, regardless of
//   the other inputs.
// TESTING
// All numbers use default parameters. E0 is the first edge sampling PWR_GOOD=1.
// 1 Power-up: RESET_N released, PWR_GOOD 0->1 at E0
//   -> DEBOUNCE entered at E2;
//   -> RST_N_OUT[0]=1 at E18, [1] at E26, [2] at E34;
//   -> [3] and READY=1 at E42, STAGE=4.
// 2 Glitch: PWR_GOOD high for 10 synced cycles, low 1 cycle, then high
//   -> RST_N_OUT stays 0000;
//   -> release starts 16 cycles after the final rise is synced;
//   -> EVT_CNT=0.
// 3 Brown-out in RUN: PWR_GOOD falls at edge Ex
//   -> RST_N_OUT=0000, READY=0, STAGE=0 at Ex+3;
//   -> EVT_CNT=1; on recovery, the sequence of scenario 1 repeats.
// 4 SW_RST pulse of 5 cycles in RELEASE after channel 1 is released
//   -> all outputs 0 on the next edge, EVT_CNT unchanged;
//   -> channel 0 released 17 edges after SW_RST falls.
// 5 Simultaneous SW_RST=1 and pg_s=0 in RUN
//   -> outputs 0 on the next edge, EVT_CNT increments by 1;
//   -> 300 brown-outs leave EVT_CNT=255.
// 6 RESET_N=0 while STAGE=2
//   -> outputs 0 and EVT_CNT=0 on that edge;
//   -> NUM_CH=1, STAGE_DELAY=1 build: READY and RST_N_OUT[0] rise on the same edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-on / brown-out reset supervisor: synchronises PWR_GOOD, debounces it, then
// releases NUM_CH active-low reset domains in index order, STAGE_DELAY cycles apart.
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int DEBOUNCE    = 16,
    parameter int STAGE_DELAY = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         PWR_GOOD,
    input  logic                         SW_RST,
    output logic [NUM_CH-1:0]            RST_N_OUT,
    output logic                         READY,
    output logic [$clog2(NUM_CH+1)-1:0]  STAGE,
    output logic [7:0]                   EVT_CNT
);

    localparam int SW   = $clog2(NUM_CH + 1);
    localparam int CMAX = (DEBOUNCE > STAGE_DELAY) ? DEBOUNCE : STAGE_DELAY;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [SYNC_STAGES-1:0] sync;
    logic                   pg_s;
    logic [1:0]             state;
    logic [CW-1:0]          cnt;

    assign pg_s = sync[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync      <= '0;
            state     <= S_HOLD;
            cnt       <= '0;
            RST_N_OUT <= '0;
            READY     <= 1'b0;
            STAGE     <= '0;
            EVT_CNT   <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], PWR_GOOD};
            case (state)
                S_HOLD: begin
                    RST_N_OUT <= '0;
                    READY     <= 1'b0;
                    STAGE     <= '0;
                    cnt       <= '0;
                    if (pg_s && !SW_RST) state <= S_DEB;
                end
                S_DEB: begin
                    if (!pg_s || SW_RST) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else if (cnt == CW'(DEBOUNCE - 1)) begin
                        cnt          <= '0;
                        RST_N_OUT[0] <= 1'b1;
                        STAGE        <= SW'(1);
                        // A single domain is fully released on debounce exit
                        if (NUM_CH == 1) begin
                            READY <= 1'b1;
                            state <= S_RUN;
                        end else begin
                            state <= S_REL;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_REL, S_RUN: begin
                    if (!pg_s || SW_RST) begin
                        // Supply loss wins over a simultaneous software request
                        state     <= S_HOLD;
                        cnt       <= '0;
                        RST_N_OUT <= '0;
                        READY     <= 1'b0;
                        STAGE     <= '0;
                        if (!pg_s && EVT_CNT != 8'hFF) EVT_CNT <= EVT_CNT + 8'd1;
                    end else if (state == S_REL) begin
                        if (cnt == CW'(STAGE_DELAY - 1)) begin
                            cnt   <= '0;
                            STAGE <= STAGE + SW'(1);
                            for (int i = 0; i < NUM_CH; i++)
                                if (SW'(i) == STAGE) RST_N_OUT[i] <= 1'b1;
                            if (STAGE == SW'(NUM_CH - 1)) begin
                                READY <= 1'b1;
                                state <= S_RUN;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized supply/software-reset
// traffic compared against a run-length model of the sequencing rules.
module tb_reset_sequencer;

    localparam int DEB = 16;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       PWR_GOOD = 1'b0;
    logic       SW_RST = 1'b0;
    logic [3:0] rst_n_out;
    logic       ready;
    logic [2:0] stage;
    logic [7:0] evt_cnt;
    logic [0:0] rst1;
    logic       ready1;
    logic [0:0] stage1;
    logic [7:0] evt1;

    int checks = 0;
    int errors = 0;

    // Model: the outputs depend only on how many consecutive edges have seen
    // synced-good with no software request, plus the brown-out count.
    bit [1:0] m_hist;
    int       m_run;
    int       m_evt;

    reset_sequencer #(.NUM_CH(4), .DEBOUNCE(DEB), .STAGE_DELAY(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .PWR_GOOD(PWR_GOOD), .SW_RST(SW_RST),
        .RST_N_OUT(rst_n_out), .READY(ready), .STAGE(stage), .EVT_CNT(evt_cnt));

    reset_sequencer #(.NUM_CH(1), .DEBOUNCE(DEB), .STAGE_DELAY(1), .SYNC_STAGES(2)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .PWR_GOOD(PWR_GOOD), .SW_RST(SW_RST),
        .RST_N_OUT(rst1), .READY(ready1), .STAGE(stage1), .EVT_CNT(evt1));

    always #5 CLK = ~CLK;

    function automatic int rel_of(int run, int nch, int sd);
        int r;
        if (run < DEB + 1) return 0;
        r = 1 + (run - DEB - 1) / sd;
        return (r > nch) ? nch : r;
    endfunction

    task automatic tick();
        bit pg_s;
        @(posedge CLK);
        if (!RESET_N) begin
            m_hist = '0;
            m_run  = 0;
            m_evt  = 0;
        end else begin
            pg_s = m_hist[1];
            if (pg_s && !SW_RST) begin
                if (m_run < 1000000) m_run++;
            end else begin
                if (!pg_s && rel_of(m_run, 4, 8) > 0 && m_evt < 255) m_evt++;
                m_run = 0;
            end
            m_hist = {m_hist[0], PWR_GOOD};
        end
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; PWR_GOOD = 1'b1; SW_RST = 1'b0;
        ticks(2);
        checks++;
        if (rst_n_out !== 4'h0 || ready !== 1'b0 || stage !== 3'd0 || evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset: rst=%h ready=%b stage=%0d evt=%0d, want 0/0/0/0",
                     rst_n_out, ready, stage, evt_cnt);
        end
    endtask

    task automatic test_power_up();
        logic [3:0] exp_rst;
        RESET_N = 1'b1; PWR_GOOD = 1'b0;
        ticks(3);
        PWR_GOOD = 1'b1;
        for (int e = 0; e <= 44; e++) begin
            tick();
            exp_rst = (e >= 42) ? 4'hF : (e >= 34) ? 4'h7 : (e >= 26) ? 4'h3 : (e >= 18) ? 4'h1 : 4'h0;
            checks++;
            if (rst_n_out !== exp_rst || ready !== (e >= 42) ||
                stage !== ((e >= 42) ? 3'd4 : (e >= 34) ? 3'd3 : (e >= 26) ? 3'd2 : (e >= 18) ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL power_up E%0d: rst=%h ready=%b stage=%0d, want rst=%h", e,
                         rst_n_out, ready, stage, exp_rst);
            end
        end
    endtask

    task automatic test_glitch();
        RESET_N = 1'b0; tick();
        RESET_N = 1'b1; PWR_GOOD = 1'b0; ticks(2);
        PWR_GOOD = 1'b1; ticks(10);
        PWR_GOOD = 1'b0; tick();
        PWR_GOOD = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            tick();
            checks++;
            if (rst_n_out !== ((k == 18) ? 4'h1 : 4'h0) || evt_cnt !== 8'd0) begin
                errors++;
                $display("FAIL glitch F+%0d: rst=%h evt=%0d, want rst=%h evt=0", k,
                         rst_n_out, evt_cnt, (k == 18) ? 4'h1 : 4'h0);
            end
        end
    endtask

    task automatic test_brown_out();
        ticks(30);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL brown_out_pre: ready=%b want 1", ready);
        end
        PWR_GOOD = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (rst_n_out !== ((k == 3) ? 4'h0 : 4'hF) || ready !== (k != 3) ||
                stage !== ((k == 3) ? 3'd0 : 3'd4) || evt_cnt !== ((k == 3) ? 8'd1 : 8'd0)) begin
                errors++;
                $display("FAIL brown_out Ex+%0d: rst=%h ready=%b stage=%0d evt=%0d", k,
                         rst_n_out, ready, stage, evt_cnt);
            end
        end
        PWR_GOOD = 1'b1;
        for (int e = 0; e <= 42; e++) begin
            tick();
            if (e == 17 || e == 18 || e == 41 || e == 42) begin
                checks++;
                if (rst_n_out !== ((e == 17) ? 4'h0 : (e == 18) ? 4'h1 : (e == 41) ? 4'h7 : 4'hF) ||
                    ready !== (e == 42) || evt_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL recovery E%0d: rst=%h ready=%b evt=%0d", e, rst_n_out, ready, evt_cnt);
                end
            end
        end
    endtask

    task automatic test_sw_rst();
        SW_RST = 1'b1; tick();
        SW_RST = 1'b0; ticks(25);
        checks++;
        if (stage !== 3'd2 || rst_n_out !== 4'h3) begin
            errors++;
            $display("FAIL sw_rst_pre: stage=%0d rst=%h want 2/3", stage, rst_n_out);
        end
        SW_RST = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (rst_n_out !== 4'h0 || ready !== 1'b0 || stage !== 3'd0 || evt_cnt !== 8'd1) begin
                errors++;
                $display("FAIL sw_rst hold %0d: rst=%h stage=%0d evt=%0d want 0/0/1", k,
                         rst_n_out, stage, evt_cnt);
            end
        end
        SW_RST = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            checks++;
            if (rst_n_out !== ((k == 17) ? 4'h1 : 4'h0)) begin
                errors++;
                $display("FAIL sw_rst release +%0d: rst=%h want %h", k, rst_n_out,
                         (k == 17) ? 4'h1 : 4'h0);
            end
        end
    endtask

    task automatic test_simultaneous();
        ticks(30);
        PWR_GOOD = 1'b0;
        ticks(2);
        checks++;
        if (rst_n_out !== 4'hF) begin
            errors++;
            $display("FAIL simul_pre: rst=%h want f", rst_n_out);
        end
        SW_RST = 1'b1;
        tick();
        checks++;
        if (rst_n_out !== 4'h0 || ready !== 1'b0 || evt_cnt !== 8'd2) begin
            errors++;
            $display("FAIL simul: rst=%h ready=%b evt=%0d want 0/0/2", rst_n_out, ready, evt_cnt);
        end
        SW_RST = 1'b0;
        for (int i = 0; i < 300; i++) begin
            PWR_GOOD = 1'b1; ticks(20);
            PWR_GOOD = 1'b0; ticks(3);
        end
        checks++;
        if (evt_cnt !== 8'd255 || rst_n_out !== 4'h0) begin
            errors++;
            $display("FAIL evt_saturate: evt=%0d rst=%h want 255/0", evt_cnt, rst_n_out);
        end
    endtask

    task automatic test_reset_mid();
        PWR_GOOD = 1'b1; ticks(27);
        checks++;
        if (stage !== 3'd2) begin
            errors++;
            $display("FAIL reset_mid_pre: stage=%0d want 2", stage);
        end
        RESET_N = 1'b0;
        tick();
        checks++;
        if (rst_n_out !== 4'h0 || ready !== 1'b0 || stage !== 3'd0 || evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: rst=%h ready=%b stage=%0d evt=%0d want 0", rst_n_out,
                     ready, stage, evt_cnt);
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_single_ch();
        RESET_N = 1'b0; tick();
        RESET_N = 1'b1; PWR_GOOD = 1'b0; ticks(2);
        PWR_GOOD = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            tick();
            checks++;
            if (ready1 !== (e >= 18) || rst1 !== ((e >= 18) ? 1'b1 : 1'b0) ||
                stage1 !== ((e >= 18) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL single_ch E%0d: ready=%b rst=%b stage=%0d", e, ready1, rst1, stage1);
            end
        end
    endtask

    task automatic test_random();
        int r, r1, er;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) PWR_GOOD = ~PWR_GOOD;
            if ($urandom_range(0, 59) == 0) SW_RST = 1'b1;
            else if ($urandom_range(0, 3) == 0) SW_RST = 1'b0;
            RESET_N = ($urandom_range(0, 599) != 0);
            tick();
            r  = rel_of(m_run, 4, 8);
            r1 = rel_of(m_run, 1, 1);
            er = (1 << r) - 1;
            checks++;
            if (rst_n_out !== er[3:0] || ready !== (r == 4) || stage !== r[2:0] ||
                evt_cnt !== m_evt[7:0]) begin
                errors++;
                $display("FAIL random c%0d: rst=%h ready=%b stage=%0d evt=%0d want %h/%0d/%0d/%0d",
                         c, rst_n_out, ready, stage, evt_cnt, er[3:0], r == 4, r, m_evt);
            end
            checks++;
            if (rst1 !== r1[0:0] || ready1 !== (r1 == 1) || evt1 !== m_evt[7:0]) begin
                errors++;
                $display("FAIL random1 c%0d: rst=%b ready=%b evt=%0d want %0d/%0d", c, rst1,
                         ready1, evt1, r1, m_evt);
            end
        end
    endtask

    initial begin
        m_hist = '0; m_run = 0; m_evt = 0;
        test_reset();
        test_power_up();
        test_glitch();
        test_brown_out();
        test_sw_rst();
        test_simultaneous();
        test_reset_mid();
        test_single_ch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
